// File: rtl/word_guess_engine.sv
// word_guess_engine
//   Word-guessing game controller. A free-running LFSR supplies the secret
//   word index; the word is latched from an external combinational ROM. Each
//   submitted character is compared against one position per cycle, so every
//   matching position is revealed. The controller counts wrong guesses, spots
//   repeated guesses, and flags win or lose.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   next        advance/submit strobe (used in INIT, GUESS, WIN, LOSE)
//   guess_char  guessed character, sampled together with next in GUESS
//   word_data   ROM word, position i at [i*CHAR_W +: CHAR_W]
//   word_idx    ROM address of the current secret word
//   ready       high only while waiting for a guess
//   mask        bit i set once position i has been revealed
//   tries       wrong guesses so far (saturating)
//   hit         one-cycle pulse: the guess revealed at least one new position
//   miss        one-cycle pulse: the guess matched no position
//   win, lose   sticky result flags, cleared when a new game starts
//   state_o     current state encoding (debug)
module word_guess_engine #(
  parameter int                WORD_LEN  = 5,
  parameter int                CHAR_W    = 8,
  parameter int                MAX_TRIES = 7,
  parameter int                NUM_WORDS = 8,
  parameter int                LFSR_W    = 6,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 6'b100001,
  localparam int               IDX_W     = $clog2(NUM_WORDS),
  localparam int               TRY_W     = $clog2(MAX_TRIES + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       next,
  input  logic [CHAR_W-1:0]          guess_char,
  input  logic [WORD_LEN*CHAR_W-1:0] word_data,
  output logic [IDX_W-1:0]           word_idx,
  output logic                       ready,
  output logic [WORD_LEN-1:0]        mask,
  output logic [TRY_W-1:0]           tries,
  output logic                       hit,
  output logic                       miss,
  output logic                       win,
  output logic                       lose,
  output logic [2:0]                 state_o
);

  localparam int POS_W = $clog2(WORD_LEN);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_GEN   = 3'd1,
    S_LOAD  = 3'd2,
    S_GUESS = 3'd3,
    S_SCAN  = 3'd4,
    S_JUDGE = 3'd5,
    S_WIN   = 3'd6,
    S_LOSE  = 3'd7
  } state_t;

  state_t                     state_q, state_d;
  logic [LFSR_W-1:0]          lfsr_q, lfsr_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [WORD_LEN-1:0]        mask_q, mask_d;
  logic [TRY_W-1:0]           tries_q, tries_d;
  logic [POS_W-1:0]           pos_q, pos_d;
  logic                       any_hit_q, any_hit_d;
  logic                       any_new_q, any_new_d;
  logic                       win_q, win_d;
  logic                       lose_q, lose_d;
  logic [WORD_LEN*CHAR_W-1:0] word_q, word_d;
  logic [CHAR_W-1:0]          guess_q, guess_d;

  // Wrong-guess counter never wraps past MAX_TRIES.
  function automatic logic [TRY_W-1:0] sat_inc(input logic [TRY_W-1:0] t);
    return (t == TRY_W'(MAX_TRIES)) ? t : t + 1'b1;
  endfunction

  always_comb begin
    state_d   = state_q;
    lfsr_d    = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    idx_d     = idx_q;
    mask_d    = mask_q;
    tries_d   = tries_q;
    pos_d     = pos_q;
    any_hit_d = any_hit_q;
    any_new_d = any_new_q;
    win_d     = win_q;
    lose_d    = lose_q;
    word_d    = word_q;
    guess_d   = guess_q;
    ready     = 1'b0;
    hit       = 1'b0;
    miss      = 1'b0;

    case (state_q)
      S_INIT: begin
        mask_d  = '0;
        tries_d = '0;
        win_d   = 1'b0;
        lose_d  = 1'b0;
        if (next) state_d = S_GEN;
      end
      S_GEN: begin
        idx_d   = lfsr_q[IDX_W-1:0];
        state_d = S_LOAD;
      end
      S_LOAD: begin
        word_d  = word_data;
        state_d = S_GUESS;
      end
      S_GUESS: begin
        ready = 1'b1;
        if (next) begin
          guess_d   = guess_char;
          pos_d     = '0;
          any_hit_d = 1'b0;
          any_new_d = 1'b0;
          state_d   = S_SCAN;
        end
      end
      S_SCAN: begin
        // Constant-indexed loop picks the current position without a
        // variable-width part-select.
        for (int i = 0; i < WORD_LEN; i++) begin
          if (pos_q == POS_W'(i) && word_q[i*CHAR_W +: CHAR_W] == guess_q) begin
            any_hit_d = 1'b1;
            if (!mask_q[i]) begin
              mask_d[i] = 1'b1;
              any_new_d = 1'b1;
            end
          end
        end
        if (pos_q == POS_W'(WORD_LEN - 1)) state_d = S_JUDGE;
        else                               pos_d   = pos_q + 1'b1;
      end
      S_JUDGE: begin
        if (any_new_q) begin
          hit = 1'b1;
          // mask_q already holds the last position written during SCAN.
          if (&mask_q) begin
            win_d   = 1'b1;
            state_d = S_WIN;
          end else begin
            state_d = S_GUESS;
          end
        end else if (any_hit_q) begin
          // Character already fully revealed: no penalty.
          state_d = S_GUESS;
        end else begin
          miss    = 1'b1;
          tries_d = sat_inc(tries_q);
          if (tries_q == TRY_W'(MAX_TRIES - 1)) begin
            lose_d  = 1'b1;
            state_d = S_LOSE;
          end else begin
            state_d = S_GUESS;
          end
        end
      end
      S_WIN, S_LOSE: begin
        if (next) state_d = S_INIT;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_INIT;
      lfsr_q    <= LFSR_W'(1);
      idx_q     <= '0;
      mask_q    <= '0;
      tries_q   <= '0;
      pos_q     <= '0;
      any_hit_q <= 1'b0;
      any_new_q <= 1'b0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      idx_q     <= idx_d;
      mask_q    <= mask_d;
      tries_q   <= tries_d;
      pos_q     <= pos_d;
      any_hit_q <= any_hit_d;
      any_new_q <= any_new_d;
      win_q     <= win_d;
      lose_q    <= lose_d;
    end
  end

  // Word and guess holding registers are only read after being loaded.
  always_ff @(posedge clk) begin
    word_q  <= word_d;
    guess_q <= guess_d;
  end

  assign word_idx = idx_q;
  assign mask     = mask_q;
  assign tries    = tries_q;
  assign win      = win_q;
  assign lose     = lose_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_word_guess_engine.sv
module tb_word_guess_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        next;
  logic [7:0]  guess_char;
  logic [39:0] word_data;
  logic [2:0]  word_idx;
  logic        ready;
  logic [4:0]  mask;
  logic [2:0]  tries;
  logic        hit, miss, win, lose;
  logic [2:0]  state_o;

  always #5 clk = ~clk;

  // ROM: every address returns "HELLO", position 0 in the low byte.
  assign word_data = {8'h4F, 8'h4C, 8'h4C, 8'h45, 8'h48};

  word_guess_engine dut (
    .clk        (clk),
    .reset      (reset),
    .next       (next),
    .guess_char (guess_char),
    .word_data  (word_data),
    .word_idx   (word_idx),
    .ready      (ready),
    .mask       (mask),
    .tries      (tries),
    .hit        (hit),
    .miss       (miss),
    .win        (win),
    .lose       (lose),
    .state_o    (state_o)
  );

  // Reference LFSR: shift left, feedback = XOR of bits under the tap mask.
  logic [5:0] model_lfsr;
  always @(posedge clk) begin
    if (reset) model_lfsr <= 6'd1;
    else       model_lfsr <= {model_lfsr[4:0], ^(model_lfsr & 6'b100001)};
  end

  typedef struct {
    logic [7:0] g;
    logic [4:0] m;
    logic [2:0] t;
    logic       h;
    logic       ms;
    logic       w;
    logic       l;
    logic [2:0] st;
  } vec_t;

  vec_t tab [0:13];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [2:0] exp_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 20 && ready !== 1'b1; i++) @(negedge clk);
    chk("ready_wait", {31'd0, ready}, 32'd1);
  endtask

  // Submit one guess; check the JUDGE cycle and the cycle after it.
  task automatic run_vec(input int k);
    wait_ready();
    guess_char = tab[k].g;
    next       = 1'b1;
    @(negedge clk);                      // cycle 1: SCAN pos0
    next       = 1'b0;
    guess_char = ~tab[k].g;              // must not affect the scan
    chk("scan_state", state_o, 4);
    next = 1'b1;                         // ignored in SCAN
    @(negedge clk);                      // cycle 2
    next = 1'b0;
    repeat (4) @(negedge clk);           // cycle 6: JUDGE
    chk("judge_state", state_o, 5);
    chk("hit_pulse", hit, tab[k].h);
    chk("miss_pulse", miss, tab[k].ms);
    @(negedge clk);                      // cycle 7
    chk("mask", mask, tab[k].m);
    chk("tries", tries, tab[k].t);
    chk("win", win, tab[k].w);
    chk("lose", lose, tab[k].l);
    chk("post_state", state_o, tab[k].st);
    chk("hit_cleared", hit, 0);
    chk("miss_cleared", miss, 0);
  endtask

  // From an INIT cycle: next -> GEN -> LOAD -> GUESS.
  task automatic start_game();
    next = 1'b1;
    @(negedge clk);
    next = 1'b0;
    chk("gen_state", state_o, 1);
    exp_idx = model_lfsr[2:0];
    @(negedge clk);
    chk("load_state", state_o, 2);
    chk("word_idx", word_idx, exp_idx);
    @(negedge clk);
    chk("guess_ready", ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    tab[0] = '{8'h4C, 5'b01100, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3};
    tab[1] = '{8'h4C, 5'b01100, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3};
    tab[2] = '{8'h48, 5'b01101, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3};
    tab[3] = '{8'h45, 5'b01111, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3};
    tab[4] = '{8'h4F, 5'b11111, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd6};
    for (int i = 0; i < 7; i++)
      tab[5+i] = '{8'h5A, 5'b00000, 3'(i + 1), 1'b0, 1'b1, 1'b0,
                   (i == 6), (i == 6) ? 3'd7 : 3'd3};
    tab[12] = '{8'h5A, 5'b00000, 3'd1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3};
    tab[13] = '{8'h48, 5'b00001, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd3};

    reset = 1'b1;
    next = 1'b0;
    guess_char = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", state_o, 0);
    chk("rst_mask", mask, 0);
    chk("rst_tries", tries, 0);
    chk("rst_win", win, 0);
    chk("rst_lose", lose, 0);
    chk("rst_word_idx", word_idx, 0);
    chk("rst_ready", ready, 0);

    // First game: lfsr 1 -> 3 on the edge entering GEN, so word_idx = 3.
    reset = 1'b0;
    next = 1'b1;
    @(negedge clk);
    next = 1'b0;
    chk("first_gen_state", state_o, 1);
    @(negedge clk);
    chk("first_word_idx", word_idx, 3);
    @(negedge clk);
    chk("first_ready", ready, 1);
    chk("first_guess_state", state_o, 3);

    for (int k = 0; k <= 4; k++) run_vec(k);

    // WIN holds; next returns to INIT, which then clears the flags.
    repeat (2) @(negedge clk);
    chk("win_hold_state", state_o, 6);
    chk("win_hold_mask", mask, 5'b11111);
    chk("win_hold_flag", win, 1);
    next = 1'b1;
    @(negedge clk);
    next = 1'b0;
    chk("win_to_init", state_o, 0);
    @(negedge clk);
    chk("init_mask_clr", mask, 0);
    chk("init_win_clr", win, 0);

    start_game();
    for (int k = 5; k <= 11; k++) run_vec(k);

    repeat (2) @(negedge clk);
    chk("lose_hold_state", state_o, 7);
    chk("lose_hold_tries", tries, 7);
    chk("lose_hold_flag", lose, 1);
    next = 1'b1;
    @(negedge clk);
    next = 1'b0;
    chk("lose_to_init", state_o, 0);
    @(negedge clk);
    chk("init_tries_clr", tries, 0);
    chk("init_lose_clr", lose, 0);
    chk("init_mask_clr2", mask, 0);

    start_game();
    for (int k = 12; k <= 13; k++) run_vec(k);

    // Reset three cycles into a scan.
    wait_ready();
    guess_char = 8'h45;
    next = 1'b1;
    @(negedge clk);
    next = 1'b0;
    @(negedge clk);
    next = 1'b1;
    @(negedge clk);
    next = 1'b0;
    chk("midscan_state", state_o, 4);
    reset = 1'b1;
    @(negedge clk);
    chk("midscan_rst_state", state_o, 0);
    chk("midscan_rst_mask", mask, 0);
    chk("midscan_rst_tries", tries, 0);
    chk("midscan_rst_ready", ready, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_state", state_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
